pulse_burst_gen: RTL
====================

Name: pulse_burst_gen

Overview:
Programmable pulse-train transmitter. It produces the qualified single-clock-domain pulse stream that the team's pulse counters and timeout blocks consume. On a start request it emits exactly COUNT pulses, each HIGH_CYC cycles high and LOW_CYC cycles low, then flags completion. It sits between control logic and any downstream pulse-counting or timeout block.

Parameters:
CNT_W, 4, width of the pulse-count request and the pulses_sent counter
TIM_W, 8, width of the high/low phase-length fields

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  burst request; sampled only in IDLE
abort  input  1  terminate burst; sampled in HIGH/LOW and in IDLE
count  input  CNT_W  number of pulses in burst; latched on accepted start
high_cyc  input  TIM_W  cycles per high phase; latched on accepted start
low_cyc  input  TIM_W  cycles per low phase; latched on accepted start
pulse  output  1  pulse stream; high exactly when state is HIGH
busy  output  1  high in HIGH and LOW states
done  output  1  one-cycle completion strobe, high only in DONE state
pulses_sent  output  CNT_W  completed high phases in current/last burst

Behaviour:
- Reset (async, any time, including mid-burst):
  - state=IDLE.
  - pulse=0, busy=0, done=0, pulses_sent=0.
  - Latched count/high/low and phase timer cleared.
- States:
  - IDLE, HIGH, LOW, DONE.
  - pulse, busy and done are decoded from state only. No combinational path from inputs to outputs.
- IDLE:
  - start=1 and abort=0 at edge: latch count, high_cyc and low_cyc; clear pulses_sent; load phase timer.
  - Next state is HIGH, or DONE if count==0 (no pulses emitted).
  - start=1 and abort=1 in the same cycle: abort wins, remain IDLE, nothing latched.
- Phase lengths:
  - A latched value of 0 is treated as 1. Minimum phase is 1 cycle.
  - Phase timer width is TIM_W and never wraps.
- HIGH:
  - Stays for exactly max(high_cyc,1) cycles.
  - On the last cycle, pulses_sent increments.
  - If the incremented value equals the latched count, next state is DONE; otherwise LOW.
- LOW:
  - Stays for exactly max(low_cyc,1) cycles, then HIGH.
  - No trailing LOW phase after the final pulse.
- DONE:
  - Lasts exactly 1 cycle: done=1, busy=0. Then IDLE.
  - start in DONE is ignored. The earliest re-start is sampled the cycle after done.
- Latency: start sampled at edge k → pulse high from cycle k+1. Total burst from start edge to done cycle = N*H + (N-1)*L + 1 cycles.
- Input stability: start, count, high_cyc and low_cyc changes while busy have no effect.
- abort in HIGH or LOW:
  - Next state is IDLE. pulse drops the following cycle; done is never asserted.
  - pulses_sent holds the completed-pulse count. A partial high phase is not counted.
- pulses_sent:
  - Holds its value after DONE or abort until the next accepted start.
  - Cannot exceed count, so no wrap. count = 2^CNT_W-1 is legal.

Test Plan:
- Basic burst: count=3, high_cyc=2, low_cyc=3, start at cycle 0 → pulse=1 in cycles 1-2, 6-7 and 11-12; busy 1-12; done=1 only in cycle 13; pulses_sent=3.
- Zero and minimum values: count=0 → done in cycle 1, pulse never high, pulses_sent=0. count=2, high_cyc=0, low_cyc=0 → pulse high in cycles 1 and 3; done in cycle 4.
- Abort and ignored start: count=5, H=1, L=1, abort in cycle 4 → pulse low from cycle 5, no done, pulses_sent=2. A start pulsed during the burst changes nothing. start+abort together in IDLE → stays IDLE.
- Reset mid-burst: rst asserted asynchronously during HIGH of pulse 2 → pulse, busy and pulses_sent go 0 immediately. After release, a new start with count=1, H=1 gives a clean single pulse.
- Back-to-back and max count: count=15, H=1, L=1 → exactly 15 pulses, pulses_sent=15 with no wrap. start asserted in the DONE cycle is ignored; start the next cycle launches a new burst with pulses_sent cleared.
- Loopback: feed pulse into a pulse-counting block with threshold 5, count=5, H=3, L=2 → its terminal flag rises one cycle after the last pulse edge, and downstream count equals pulses_sent.

Source files
------------

// File: rtl/pulse_burst_gen.sv
// pulse_burst_gen: programmable pulse-train transmitter.
// A start request in IDLE launches a burst of `count` pulses, each
// max(high_cyc,1) cycles high and max(low_cyc,1) cycles low, with no
// trailing low phase, followed by a one-cycle done strobe.
// All outputs are decoded from registered state only.
module pulse_burst_gen #(
  parameter int CNT_W = 4,
  parameter int TIM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] count,
  input  logic [TIM_W-1:0] high_cyc,
  input  logic [TIM_W-1:0] low_cyc,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_sent
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [TIM_W-1:0] high_q, high_d;
  logic [TIM_W-1:0] low_q, low_d;
  logic [TIM_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] sent_inc;

  // The timer counts down the cycles remaining in the current phase and
  // is loaded with (length - 1); a zero length behaves as one cycle, so
  // the load value is 0 for both 0 and 1 and the timer never wraps.
  function automatic logic [TIM_W-1:0] phase_last(input logic [TIM_W-1:0] len);
    return (len == '0) ? '0 : len - TIM_W'(1);
  endfunction

  assign sent_inc = sent_q + CNT_W'(1);

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      sent_q  <= '0;
      high_q  <= '0;
      low_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sent_q  <= sent_d;
      high_q  <= high_d;
      low_q   <= low_d;
      timer_q <= timer_d;
    end
  end

  // Next-state and datapath update; everything holds unless a case changes it.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sent_d  = sent_q;
    high_d  = high_q;
    low_d   = low_q;
    timer_d = timer_q;
    unique case (state_q)
      S_IDLE: begin
        // abort in the same cycle as start cancels the request entirely
        if (start && !abort) begin
          count_d = count;
          high_d  = high_cyc;
          low_d   = low_cyc;
          sent_d  = '0;
          timer_d = phase_last(high_cyc);
          state_d = (count == '0) ? S_DONE : S_HIGH;
        end
      end
      S_HIGH: begin
        if (abort) begin
          // a partially emitted high phase is not counted
          state_d = S_IDLE;
          timer_d = '0;
        end else if (timer_q == '0) begin
          sent_d = sent_inc;
          if (sent_inc == count_q) begin
            state_d = S_DONE;
            timer_d = '0;
          end else begin
            state_d = S_LOW;
            timer_d = phase_last(low_q);
          end
        end else begin
          timer_d = timer_q - TIM_W'(1);
        end
      end
      S_LOW: begin
        if (abort) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (timer_q == '0) begin
          state_d = S_HIGH;
          timer_d = phase_last(high_q);
        end else begin
          timer_d = timer_q - TIM_W'(1);
        end
      end
      S_DONE: begin
        // start is ignored here; the earliest restart is sampled in IDLE
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pulse       = (state_q == S_HIGH);
  assign busy        = (state_q == S_HIGH) || (state_q == S_LOW);
  assign done        = (state_q == S_DONE);
  assign pulses_sent = sent_q;

endmodule
